// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, single-outstanding memory request, one-deep
// skid buffer and the fetch/decode pipeline register with stall, flush and redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallf,
  input  logic        stalld,
  input  logic        flushd,
  input  logic        pcSrce,
  input  logic [31:0] pcTargete,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGnt,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  output logic [31:0] instrd,
  output logic [31:0] pcd,
  output logic [31:0] pcPlus4d,
  output logic        validd
);

  typedef enum logic {FETCH, WAIT} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pcf;
  logic [31:0] req_pc;
  logic        kill;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic handshake;
  logic rsp;
  logic deliver;
  logic decode_free;
  logic move;
  logic to_decode;
  logic to_skid;

  // Next-state and request generation; only one request may be outstanding.
  always_comb begin
    state_next = state;
    imemReq    = 1'b0;
    case (state)
      FETCH: begin
        imemReq = !rst && !stallf && !skid_valid && !pcSrce;
        if (imemReq && imemGnt) state_next = WAIT;
      end
      WAIT: begin
        if (imemRvalid) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  assign handshake   = imemReq & imemGnt;
  assign rsp         = (state == WAIT) & imemRvalid;
  assign deliver     = rsp & !kill & !pcSrce;
  assign decode_free = !validd || !stalld;
  // A parked skid entry always enters decode ahead of a fresh response.
  assign move        = skid_valid & decode_free;
  assign to_decode   = deliver & decode_free & !skid_valid;
  assign to_skid     = deliver & !to_decode;

  assign imemAddr = pcf;
  assign pcPlus4d = pcd + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      pcf        <= RESET_PC;
      req_pc     <= RESET_PC;
      kill       <= 1'b0;
      skid_valid <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= 32'h0000_0000;
      validd     <= 1'b0;
      instrd     <= NOP_INSTR;
      pcd        <= 32'h0000_0000;
    end else begin
      // Redirect wins over increment; a request still in flight gets killed.
      if (pcSrce) begin
        pcf  <= pcTargete;
        kill <= (state == WAIT) && !imemRvalid;
      end else begin
        if (handshake) begin
          pcf    <= pcf + 32'd4;
          req_pc <= pcf;
        end
        if (rsp) kill <= 1'b0;
      end

      if (pcSrce) begin
        skid_valid <= 1'b0;
      end else if (to_skid) begin
        skid_valid <= 1'b1;
        skid_instr <= imemRdata;
        skid_pc    <= req_pc;
      end else if (move) begin
        skid_valid <= 1'b0;
      end

      if (flushd) begin
        validd <= 1'b0;
        instrd <= NOP_INSTR;
      end else if (move) begin
        validd <= 1'b1;
        instrd <= skid_instr;
        pcd    <= skid_pc;
      end else if (to_decode) begin
        validd <= 1'b1;
        instrd <= imemRdata;
        pcd    <= req_pc;
      end else if (decode_free) begin
        validd <= 1'b0;
        instrd <= NOP_INSTR;
      end
    end
  end

endmodule
